rc4_ksa: RTL

RC4_KSA -- requirements
Module: rc4_ksa

---
 rtl/rc4_ksa.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rc4_ksa.sv
// rc4_ksa: RC4 key schedule over a 16-entry, 4-bit state, driving a dual-write port into an external 16x4 store.
//   clk, rst (async, active-high), start (begin a schedule), key (KEY_NIB nibbles, K[0] = key[3:0])
//   busy (schedule in progress), done (one-cycle completion pulse)
//   wr_en, wr_addr1/wr_data1, wr_addr2/wr_data2 (registered dual write into the downstream store)
module rc4_ksa #(
  parameter int KEY_NIB = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*KEY_NIB-1:0]   key,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_en,
  output logic [3:0]             wr_addr1,
  output logic [3:0]             wr_addr2,
  output logic [3:0]             wr_data1,
  output logic [3:0]             wr_data2
);
  typedef enum logic [1:0] {IDLE, INIT, MIX, FIN} state_t;
  state_t state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [3:0] i_q, i_d, j_q, j_d, kx_q, kx_d;
  logic [3:0] s_q [16];
  logic [3:0] s_d [16];
  logic [3:0] kn, si, sj, jn;
  logic busy_d, done_d, wr_en_d;
  logic [3:0] a1_d, a2_d, d1_d, d2_d;
  // kx_q tracks i mod KEY_NIB as a wrapping counter; the key is zero-padded to 16 nibbles
  assign kn = key_q[{kx_q, 2'b00} +: 4];
  assign si = s_q[i_q];
  assign jn = j_q + si + kn;
  assign sj = s_q[jn];
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    i_d = i_q;
    j_d = j_q;
    kx_d = kx_q;
    s_d = s_q;
    wr_en_d = 1'b0;
    done_d = 1'b0;
    a1_d = '0;
    a2_d = '0;
    d1_d = '0;
    d2_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          key_d = 64'(key);
          i_d = '0;
        end
      end
      INIT: begin
        wr_en_d = 1'b1;
        a1_d = {i_q[2:0], 1'b0};
        a2_d = {i_q[2:0], 1'b1};
        d1_d = a1_d;
        d2_d = a2_d;
        s_d[a1_d] = a1_d;
        s_d[a2_d] = a2_d;
        i_d = i_q + 4'd1;
        j_d = '0;
        kx_d = '0;
        if (i_q == 4'd7) begin
          state_d = MIX;
          i_d = '0;
        end
      end
      MIX: begin
        // when jn == i both ports carry (i, S[i]) and the swap is a no-op
        wr_en_d = 1'b1;
        a1_d = i_q;
        d1_d = sj;
        a2_d = jn;
        d2_d = si;
        s_d[i_q] = sj;
        s_d[jn] = si;
        j_d = jn;
        i_d = i_q + 4'd1;
        kx_d = (kx_q == 4'(KEY_NIB - 1)) ? '0 : kx_q + 4'd1;
        if (i_q == 4'd15) state_d = FIN;
      end
      default: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q <= '0;
      i_q <= '0;
      j_q <= '0;
      kx_q <= '0;
      for (int k = 0; k < 16; k++) s_q[k] <= 4'(k);
      busy <= 1'b0;
      done <= 1'b0;
      wr_en <= 1'b0;
      wr_addr1 <= '0;
      wr_addr2 <= '0;
      wr_data1 <= '0;
      wr_data2 <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      i_q <= i_d;
      j_q <= j_d;
      kx_q <= kx_d;
      s_q <= s_d;
      busy <= busy_d;
      done <= done_d;
      wr_en <= wr_en_d;
      wr_addr1 <= a1_d;
      wr_addr2 <= a2_d;
      wr_data1 <= d1_d;
      wr_data2 <= d2_d;
    end
  end
endmodule
